// File: rtl/if_stage_n_pkg.sv
// rtl/if_stage_n_pkg.sv - shared types and constants for the instruction fetch stage
package if_stage_n_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } fetch_state_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_FETCH_W = 2;
    localparam int DEF_PR_W    = 33;

    // Bit n set means a fetch packet of n instructions is supported (1, 2, 4)
    localparam logic [4:0] FETCH_W_LEGAL = 5'b10110;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]     pc;
        logic [32*DEF_FETCH_W-1:0] inst;
        logic [DEF_FETCH_W-1:0]    lane_vld;
        logic [DEF_PR_W-1:0]       pr;
    } fetch_pkt_t;

    function automatic logic fetch_w_ok(input int fw);
        return (fw >= 1) && (fw <= 4) && FETCH_W_LEGAL[3'(fw)];
    endfunction

endpackage

// File: rtl/if_discard_cnt.sv
// rtl/if_discard_cnt.sv - count of issued RAM requests whose responses must be dropped
module if_discard_cnt #(
    parameter int MAX_OUT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    logic [1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == 2'(MAX_OUT));
    assign empty_o = (cnt_q == 2'd0);

    // Concurrent increment and decrement cancel; both ends saturate
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + 2'd1;
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/if_stage_n.sv
// rtl/if_stage_n.sv - single-packet instruction fetch stage with flush-safe RAM tracking
module if_stage_n
    import if_stage_n_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int FETCH_W = 2,
    parameter int PR_W    = 33,
    parameter int MAX_OUT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pre_to_now_valid_i,
    input  logic [ADDR_W-1:0]     pc_i,
    output logic                  now_allowin_o,
    input  logic                  next_allowin_i,
    output logic                  now_to_next_valid_o,
    input  logic                  excep_flush_i,
    input  logic                  other_flush_i,
    input  logic                  pr_valid_i,
    input  logic [PR_W-1:0]       pr_data_i,
    output logic                  ram_req_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    input  logic                  ram_addr_ok_i,
    input  logic                  ram_data_ok_i,
    input  logic [32*FETCH_W-1:0] ram_rdata_i,
    output logic [ADDR_W-1:0]     to_next_pc_o,
    output logic [32*FETCH_W-1:0] to_next_inst_o,
    output logic [FETCH_W-1:0]    to_next_lane_vld_o,
    output logic [PR_W-1:0]       to_next_pr_o,
    output logic [ADDR_W-1:0]     to_pre_seq_pc_o
);

    localparam int                DATA_W     = 32 * FETCH_W;
    localparam logic [ADDR_W-1:0] PKT_BYTES  = ADDR_W'(FETCH_W * 4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(FETCH_W * 4 - 1));
    localparam logic [ADDR_W-1:0] LANE_MASK  = ADDR_W'(FETCH_W - 1);

    if (!fetch_w_ok(FETCH_W) || MAX_OUT < 1 || MAX_OUT > 3) begin : g_bad_param
        $error("if_stage_n: illegal FETCH_W or MAX_OUT");
    end

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic [PR_W-1:0]     pr_buf_q, pr_buf_d;
    logic                pr_buf_vld_q, pr_buf_vld_d;

    logic                flush, resident, leaving, accept;
    logic                addr_hs, flush_addr_hs, data_hit, pr_load;
    logic                cnt_inc, cnt_dec, cnt_full, cnt_empty;
    logic [ADDR_W-1:0]   pc_aligned, word_idx;
    logic [FETCH_W-1:0]  lane_vld;

    // Both flush sources have the same effect on the stage
    assign flush         = excep_flush_i | other_flush_i;
    assign resident      = (state_q != S_IDLE);
    assign leaving       = now_to_next_valid_o & next_allowin_i;
    assign accept        = pre_to_now_valid_i & now_allowin_o & ~flush;
    assign addr_hs       = ram_req_o & ram_addr_ok_i;
    // A request the RAM took in the same cycle we flushed still returns data
    assign flush_addr_hs = flush & (state_q == S_REQ) & ~cnt_full & ram_addr_ok_i;
    assign data_hit      = (state_q == S_WAIT) & ram_data_ok_i & cnt_empty;
    // A response landing in the flush cycle is consumed now, so it is not counted
    assign cnt_inc       = flush & (((state_q == S_WAIT) & ~data_hit) | flush_addr_hs);
    assign cnt_dec       = ram_data_ok_i & ~cnt_empty;
    assign pr_load       = pr_valid_i & resident & ~leaving & ~flush;

    if_discard_cnt #(
        .MAX_OUT (MAX_OUT)
    ) u_discard_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (cnt_inc),
        .dec_i   (cnt_dec),
        .full_o  (cnt_full),
        .empty_o (cnt_empty)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ:  if (addr_hs) state_d = S_WAIT;
            S_WAIT: if (data_hit) state_d = S_DONE;
            S_DONE: if (next_allowin_i) state_d = accept ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // FSM outputs; requests are withheld while flushing or while the discard counter is full
    always_comb begin
        now_allowin_o       = (state_q == S_IDLE) | ((state_q == S_DONE) & next_allowin_i);
        now_to_next_valid_o = (state_q == S_DONE);
        ram_req_o           = (state_q == S_REQ) & ~cnt_full & ~flush;
    end

    // Packet datapath next state: pc, instruction buffer, predictor buffer
    always_comb begin
        pc_d         = accept ? pc_i : pc_q;
        inst_d       = (data_hit && !flush) ? ram_rdata_i : inst_q;
        pr_buf_d     = pr_load ? pr_data_i : pr_buf_q;
        pr_buf_vld_d = pr_buf_vld_q;
        if (leaving || flush) begin
            pr_buf_vld_d = 1'b0;
        end else if (pr_load) begin
            pr_buf_vld_d = 1'b1;
        end
    end

    // Packet datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= '0;
            inst_q       <= '0;
            pr_buf_q     <= '0;
            pr_buf_vld_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            pr_buf_q     <= pr_buf_d;
            pr_buf_vld_q <= pr_buf_vld_d;
        end
    end

    assign pc_aligned = pc_q & ALIGN_MASK;
    assign word_idx   = (pc_q >> 2) & LANE_MASK;

    // Lanes before the entry word of the packet are not valid
    always_comb begin
        lane_vld = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            lane_vld[i] = (ADDR_W'(i) >= word_idx);
        end
    end

    assign ram_addr_o         = resident ? pc_aligned : '0;
    assign to_pre_seq_pc_o    = resident ? (pc_aligned + PKT_BYTES) : '0;
    assign to_next_pc_o       = resident ? pc_q : '0;
    assign to_next_inst_o     = resident ? inst_q : '0;
    assign to_next_lane_vld_o = resident ? lane_vld : '0;
    assign to_next_pr_o       = (pr_valid_i && resident) ? pr_data_i :
                                (pr_buf_vld_q ? pr_buf_q : '0);

endmodule

// File: tb/tb_if_stage_n.sv
// tb/tb_if_stage_n.sv - scoreboard bench for if_stage_n
module tb_if_stage_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pre_to_now_valid_i;
    logic [31:0] pc_i;
    logic        now_allowin_o;
    logic        next_allowin_i;
    logic        now_to_next_valid_o;
    logic        excep_flush_i;
    logic        other_flush_i;
    logic        pr_valid_i;
    logic [32:0] pr_data_i;
    logic        ram_req_o;
    logic [31:0] ram_addr_o;
    logic        ram_addr_ok_i;
    logic        ram_data_ok_i;
    logic [63:0] ram_rdata_i;
    logic [31:0] to_next_pc_o;
    logic [63:0] to_next_inst_o;
    logic [1:0]  to_next_lane_vld_o;
    logic [32:0] to_next_pr_o;
    logic [31:0] to_pre_seq_pc_o;

    always #5 clk = ~clk;

    if_stage_n #(
        .ADDR_W  (32),
        .FETCH_W (2),
        .PR_W    (33),
        .MAX_OUT (2)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pre_to_now_valid_i  (pre_to_now_valid_i),
        .pc_i                (pc_i),
        .now_allowin_o       (now_allowin_o),
        .next_allowin_i      (next_allowin_i),
        .now_to_next_valid_o (now_to_next_valid_o),
        .excep_flush_i       (excep_flush_i),
        .other_flush_i       (other_flush_i),
        .pr_valid_i          (pr_valid_i),
        .pr_data_i           (pr_data_i),
        .ram_req_o           (ram_req_o),
        .ram_addr_o          (ram_addr_o),
        .ram_addr_ok_i       (ram_addr_ok_i),
        .ram_data_ok_i       (ram_data_ok_i),
        .ram_rdata_i         (ram_rdata_i),
        .to_next_pc_o        (to_next_pc_o),
        .to_next_inst_o      (to_next_inst_o),
        .to_next_lane_vld_o  (to_next_lane_vld_o),
        .to_next_pr_o        (to_next_pr_o),
        .to_pre_seq_pc_o     (to_pre_seq_pc_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  lane;
        logic [31:0] seq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [63:0] inst_of(input logic [31:0] pc);
        logic [31:0] a;
        a = pc & 32'hFFFF_FFF8;
        return {~a, a ^ 32'h1357_9BDF};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = inst_of(pc);
        e.lane = pc[2] ? 2'b10 : 2'b11;
        e.seq  = (pc & 32'hFFFF_FFF8) + 32'd8;
        return e;
    endfunction

    // Departure monitor: every packet taken by decode must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && now_to_next_valid_o && next_allowin_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected got pc=%h with empty scoreboard", to_next_pc_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (to_next_pc_o !== mon_e.pc || to_next_inst_o !== mon_e.inst ||
                    to_next_lane_vld_o !== mon_e.lane || to_pre_seq_pc_o !== mon_e.seq) begin
                    n_fail++;
                    $display("FAIL sb_packet got pc=%h inst=%h lane=%b seq=%h exp pc=%h inst=%h lane=%b seq=%h",
                             to_next_pc_o, to_next_inst_o, to_next_lane_vld_o, to_pre_seq_pc_o,
                             mon_e.pc, mon_e.inst, mon_e.lane, mon_e.seq);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        pre_to_now_valid_i = 1'b0;
        pc_i               = '0;
        next_allowin_i     = 1'b1;
        excep_flush_i      = 1'b0;
        other_flush_i      = 1'b0;
        pr_valid_i         = 1'b0;
        pr_data_i          = '0;
        ram_addr_ok_i      = 1'b0;
        ram_data_ok_i      = 1'b0;
        ram_rdata_i        = '0;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        cyc();
        cyc();
        n_tests++; if (now_allowin_o !== 1'b1) begin n_fail++; $display("FAIL rst_allowin got=%b exp=1", now_allowin_o); end
        n_tests++; if (ram_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", ram_req_o); end
        n_tests++; if (now_to_next_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", now_to_next_valid_o); end
        n_tests++;
        if (to_next_pc_o !== 32'd0 || to_next_inst_o !== 64'd0 || to_pre_seq_pc_o !== 32'd0 ||
            to_next_lane_vld_o !== 2'b00 || to_next_pr_o !== 33'd0 || ram_addr_o !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_data got pc=%h inst=%h seq=%h lane=%b pr=%h addr=%h exp all 0",
                     to_next_pc_o, to_next_inst_o, to_pre_seq_pc_o, to_next_lane_vld_o, to_next_pr_o, ram_addr_o);
        end
        rst_n = 1'b1;
        cyc();
        n_tests++; if (now_allowin_o !== 1'b1 || ram_req_o !== 1'b0) begin n_fail++; $display("FAIL post_rst got allowin=%b req=%b exp 1/0", now_allowin_o, ram_req_o); end
    endtask

    task automatic test_basic_fetch();
        clear_in();
        pre_to_now_valid_i = 1'b1;
        pc_i = 32'h1C00_0004;
        #1;
        n_tests++; if (now_allowin_o !== 1'b1) begin n_fail++; $display("FAIL basic_allowin got=%b exp=1", now_allowin_o); end
        cyc();
        pre_to_now_valid_i = 1'b0;
        pc_i = '0;
        ram_addr_ok_i = 1'b1;
        #1;
        n_tests++; if (ram_req_o !== 1'b1) begin n_fail++; $display("FAIL basic_req got=%b exp=1", ram_req_o); end
        n_tests++; if (ram_addr_o !== 32'h1C00_0000) begin n_fail++; $display("FAIL basic_addr got=%h exp=1c000000", ram_addr_o); end
        cyc();
        ram_addr_ok_i = 1'b0;
        ram_data_ok_i = 1'b1;
        ram_rdata_i   = inst_of(32'h1C00_0004);
        exp_q.push_back(mk_exp(32'h1C00_0004));
        #1;
        n_tests++; if (now_to_next_valid_o !== 1'b0 || ram_req_o !== 1'b0) begin n_fail++; $display("FAIL basic_wait got valid=%b req=%b exp 0/0", now_to_next_valid_o, ram_req_o); end
        cyc();
        ram_data_ok_i = 1'b0;
        #1;
        n_tests++; if (now_to_next_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_latency got valid=%b exp=1", now_to_next_valid_o); end
        n_tests++; if (to_next_lane_vld_o !== 2'b10) begin n_fail++; $display("FAIL basic_lane got=%b exp=10", to_next_lane_vld_o); end
        n_tests++; if (to_pre_seq_pc_o !== 32'h1C00_0008) begin n_fail++; $display("FAIL basic_seq got=%h exp=1c000008", to_pre_seq_pc_o); end
        cyc();
        n_tests++; if (now_to_next_valid_o !== 1'b0 || now_allowin_o !== 1'b1) begin n_fail++; $display("FAIL basic_leave got valid=%b allowin=%b exp 0/1", now_to_next_valid_o, now_allowin_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [4];
        logic        pend;
        logic [31:0] pend_pc, cur_pc;
        int          acc, dep, last_dep, gap_bad, cycle;
        pcs[0] = 32'h1C00_0404; pcs[1] = 32'h1C00_0408;
        pcs[2] = 32'h1C00_040C; pcs[3] = 32'h1C00_0410;
        clear_in();
        pend = 1'b0; pend_pc = '0; cur_pc = '0;
        acc = 0; dep = 0; last_dep = -1; gap_bad = 0; cycle = 0;
        while (dep < 4 && cycle < 40) begin
            cyc();
            cycle++;
            ram_data_ok_i = pend;
            ram_rdata_i   = pend ? inst_of(pend_pc) : 64'd0;
            if (pend) exp_q.push_back(mk_exp(pend_pc));
            pre_to_now_valid_i = (acc < 4);
            pc_i          = (acc < 4) ? pcs[acc] : 32'd0;
            ram_addr_ok_i = ram_req_o;
            #1;
            if (now_to_next_valid_o && next_allowin_i) begin
                if (last_dep >= 0 && cycle - last_dep != 3) gap_bad++;
                if (dep < 3 && !(pre_to_now_valid_i && now_allowin_o)) gap_bad++;
                last_dep = cycle;
                dep++;
            end
            pend = ram_req_o && ram_addr_ok_i;
            if (pend) pend_pc = cur_pc;
            if (pre_to_now_valid_i && now_allowin_o) begin
                cur_pc = pcs[acc];
                acc++;
            end
        end
        n_tests++; if (dep != 4) begin n_fail++; $display("FAIL b2b_timeout got %0d departures exp 4", dep); end
        n_tests++; if (gap_bad != 0) begin n_fail++; $display("FAIL b2b_bubble got %0d bubbles exp 0", gap_bad); end
        clear_in();
        cyc();
    endtask

    task automatic test_flush_discard();
        clear_in();
        pre_to_now_valid_i = 1'b1; pc_i = 32'h1C00_0100;
        cyc();
        pre_to_now_valid_i = 1'b0; ram_addr_ok_i = 1'b1;
        cyc();
        ram_addr_ok_i = 1'b0; other_flush_i = 1'b1;
        pre_to_now_valid_i = 1'b1; pc_i = 32'h1C00_0300;
        cyc();
        other_flush_i = 1'b0; pc_i = 32'h1C00_0208;
        #1;
        n_tests++; if (now_allowin_o !== 1'b1) begin n_fail++; $display("FAIL flush_drop got allowin=%b exp=1", now_allowin_o); end
        cyc();
        pre_to_now_valid_i = 1'b0; ram_addr_ok_i = 1'b1;
        #1;
        n_tests++; if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h1C00_0208) begin n_fail++; $display("FAIL flush_newreq got req=%b addr=%h exp 1/1c000208", ram_req_o, ram_addr_o); end
        cyc();
        ram_addr_ok_i = 1'b0; ram_data_ok_i = 1'b1; ram_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        cyc();
        ram_data_ok_i = 1'b0;
        #1;
        n_tests++; if (now_to_next_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_discard got valid=%b exp=0", now_to_next_valid_o); end
        ram_data_ok_i = 1'b1; ram_rdata_i = inst_of(32'h1C00_0208);
        exp_q.push_back(mk_exp(32'h1C00_0208));
        cyc();
        ram_data_ok_i = 1'b0;
        #1;
        n_tests++; if (now_to_next_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_capture got valid=%b exp=1", now_to_next_valid_o); end
        cyc();
    endtask

    task automatic test_flush_req();
        clear_in();
        pre_to_now_valid_i = 1'b1; pc_i = 32'h1C00_0500;
        cyc();
        pre_to_now_valid_i = 1'b0; excep_flush_i = 1'b1;
        #1;
        n_tests++; if (ram_req_o !== 1'b0) begin n_fail++; $display("FAIL flushreq_req got=%b exp=0", ram_req_o); end
        cyc();
        excep_flush_i = 1'b0;
        #1;
        n_tests++; if (now_allowin_o !== 1'b1 || now_to_next_valid_o !== 1'b0) begin n_fail++; $display("FAIL flushreq_idle got allowin=%b valid=%b exp 1/0", now_allowin_o, now_to_next_valid_o); end
    endtask

    task automatic test_stall_max();
        clear_in();
        pre_to_now_valid_i = 1'b1; pc_i = 32'h1C00_0700;
        cyc();
        pre_to_now_valid_i = 1'b0; ram_addr_ok_i = 1'b1;
        cyc();
        ram_addr_ok_i = 1'b0; other_flush_i = 1'b1;
        cyc();
        other_flush_i = 1'b0; pre_to_now_valid_i = 1'b1; pc_i = 32'h1C00_0710;
        cyc();
        pre_to_now_valid_i = 1'b0; ram_addr_ok_i = 1'b1; excep_flush_i = 1'b1;
        #1;
        n_tests++; if (ram_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_flushreq got=%b exp=0", ram_req_o); end
        cyc();
        ram_addr_ok_i = 1'b0; excep_flush_i = 1'b0;
        pre_to_now_valid_i = 1'b1; pc_i = 32'h1C00_0724;
        cyc();
        pre_to_now_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (ram_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_full%0d got req=%b exp=0", k, ram_req_o); end
            cyc();
        end
        ram_data_ok_i = 1'b1; ram_rdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
        #1;
        n_tests++; if (ram_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_dec_cycle got req=%b exp=0", ram_req_o); end
        cyc();
        ram_data_ok_i = 1'b0;
        #1;
        n_tests++; if (ram_req_o !== 1'b1) begin n_fail++; $display("FAIL stall_release got req=%b exp=1", ram_req_o); end
        ram_addr_ok_i = 1'b1;
        cyc();
        ram_addr_ok_i = 1'b0; ram_data_ok_i = 1'b1; ram_rdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
        cyc();
        ram_rdata_i = inst_of(32'h1C00_0724);
        exp_q.push_back(mk_exp(32'h1C00_0724));
        cyc();
        ram_data_ok_i = 1'b0;
        #1;
        n_tests++; if (now_to_next_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_capture got valid=%b exp=1", now_to_next_valid_o); end
        cyc();
    endtask

    task automatic test_pred();
        clear_in();
        next_allowin_i = 1'b0;
        pre_to_now_valid_i = 1'b1; pc_i = 32'h1C00_0604;
        cyc();
        pre_to_now_valid_i = 1'b0; ram_addr_ok_i = 1'b1;
        cyc();
        ram_addr_ok_i = 1'b0; ram_data_ok_i = 1'b1; ram_rdata_i = inst_of(32'h1C00_0604);
        exp_q.push_back(mk_exp(32'h1C00_0604));
        cyc();
        ram_data_ok_i = 1'b0;
        pr_valid_i = 1'b1; pr_data_i = 33'h155;
        #1;
        n_tests++; if (to_next_pr_o !== 33'h155) begin n_fail++; $display("FAIL pr_live got=%h exp=155", to_next_pr_o); end
        cyc();
        pr_valid_i = 1'b0; pr_data_i = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (to_next_pr_o !== 33'h155 || now_to_next_valid_o !== 1'b1) begin n_fail++; $display("FAIL pr_hold%0d got pr=%h valid=%b exp 155/1", k, to_next_pr_o, now_to_next_valid_o); end
            cyc();
        end
        next_allowin_i = 1'b1;
        #1;
        n_tests++; if (to_next_pr_o !== 33'h155) begin n_fail++; $display("FAIL pr_release got=%h exp=155", to_next_pr_o); end
        cyc();
        n_tests++; if (to_next_pr_o !== 33'd0 || now_to_next_valid_o !== 1'b0) begin n_fail++; $display("FAIL pr_clear got pr=%h valid=%b exp 0/0", to_next_pr_o, now_to_next_valid_o); end
        pr_valid_i = 1'b1; pr_data_i = 33'h0AA;
        #1;
        n_tests++; if (to_next_pr_o !== 33'd0) begin n_fail++; $display("FAIL pr_idle_live got=%h exp=0", to_next_pr_o); end
        cyc();
        pr_valid_i = 1'b0; pr_data_i = '0;
        #1;
        n_tests++; if (to_next_pr_o !== 33'd0) begin n_fail++; $display("FAIL pr_idle_buf got=%h exp=0", to_next_pr_o); end
    endtask

    task automatic test_reset_mid_wait();
        clear_in();
        pre_to_now_valid_i = 1'b1; pc_i = 32'h1C00_0800;
        cyc();
        pre_to_now_valid_i = 1'b0; ram_addr_ok_i = 1'b1;
        cyc();
        ram_addr_ok_i = 1'b0; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        n_tests++; if (now_allowin_o !== 1'b1 || now_to_next_valid_o !== 1'b0 || ram_req_o !== 1'b0) begin n_fail++; $display("FAIL midrst got allowin=%b valid=%b req=%b exp 1/0/0", now_allowin_o, now_to_next_valid_o, ram_req_o); end
        pre_to_now_valid_i = 1'b1; pc_i = 32'h1C00_0814;
        cyc();
        pre_to_now_valid_i = 1'b0; ram_addr_ok_i = 1'b1;
        cyc();
        ram_addr_ok_i = 1'b0; ram_data_ok_i = 1'b1; ram_rdata_i = inst_of(32'h1C00_0814);
        exp_q.push_back(mk_exp(32'h1C00_0814));
        cyc();
        ram_data_ok_i = 1'b0;
        #1;
        n_tests++; if (now_to_next_valid_o !== 1'b1) begin n_fail++; $display("FAIL midrst_capture got valid=%b exp=1", now_to_next_valid_o); end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_flush_discard();
        test_flush_req();
        test_stall_max();
        test_pred();
        test_reset_mid_wait();
        cyc();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d packets exp 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
